// File: rtl/egress_port_queue.sv
// Egress port queue: AXIS FIFO, registered output stage, CT/SAF/bypass modes.
// Optional packet statistics enabled by EGRESS_PORT_QUEUE_STATS_EN.
module egress_port_queue #(
  parameter int PORT_ID    = 0,
  parameter int DATA_W     = 64,
  parameter int USER_W     = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          saf_mode,
  input  logic                          axis_in_tvalid,
  input  logic [DATA_W-1:0]             axis_in_tdata,
  input  logic [DATA_W/8-1:0]           axis_in_tkeep,
  input  logic [USER_W-1:0]             axis_in_tuser,
  input  logic                          axis_in_tlast,
  output logic                          axis_in_tready,
  output logic                          ext_out_valid,
  output logic [DATA_W-1:0]             ext_out_data,
  output logic [DATA_W/8-1:0]           ext_out_keep,
  output logic [USER_W-1:0]             ext_out_user,
  output logic                          ext_out_last,
  input  logic                          ext_in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    port_id,
  output logic [CNT_W-1:0]              pkt_rx_count,
  output logic [CNT_W-1:0]              pkt_tx_count,
  output logic [CNT_W-1:0]              saf_bypass_count
);
  localparam int KW = DATA_W / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_W + KW + USER_W + 1;

  typedef enum logic [1:0] {IDLE, FWD, BYPASS} state_t;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] avail_q, avail_d, cpl_q, cpl_d;
  logic          wr_cmt_q, wr_cmt_d, last_cmt_q, last_cmt_d;
  state_t        state_q, state_d;
  logic          cur_mode_q, cur_mode_d;
  logic          ovld_q, ovld_d, olast_q, olast_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [KW-1:0]     okeep_q, okeep_d;
  logic [USER_W-1:0] ouser_q, ouser_d;

  logic          wr, load, elig, eff_saf, full, head_last, bypass_hit;
  logic [EW-1:0] head;

  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign wr        = axis_in_tvalid && !full;
  assign head      = mem_q[rd_ptr_q];
  assign head_last = head[EW-1];
  assign eff_saf   = (state_q == IDLE) ? saf_mode : cur_mode_q;
  // avail/cpl see writes one edge late, giving the two-edge input-to-output latency
  assign elig = (avail_q != '0) &&
                (state_q == BYPASS || !eff_saf || cpl_q != '0);
  assign load = elig && (!ovld_q || ext_in_ready);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(wr);
    rd_ptr_d   = rd_ptr_q + AW'(load);
    level_d    = level_q + LW'(wr) - LW'(load);
    wr_cmt_d   = wr;
    last_cmt_d = wr && axis_in_tlast;
    avail_d    = avail_q + LW'(wr_cmt_q) - LW'(load);
    cpl_d      = cpl_q + LW'(last_cmt_q) - LW'(load && head_last);
  end

  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    bypass_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (saf_mode && full && cpl_q == '0) begin
          state_d    = BYPASS;
          cur_mode_d = 1'b1;
          bypass_hit = 1'b1;
        end else if (load) begin
          cur_mode_d = saf_mode;
          state_d    = head_last ? IDLE : FWD;
        end
      end
      FWD: begin
        if (cur_mode_q && full && cpl_q == '0) begin
          state_d    = BYPASS;
          bypass_hit = 1'b1;
        end else if (load && head_last) begin
          state_d = IDLE;
        end
      end
      BYPASS: if (load && head_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovld_d  = ovld_q;
    olast_d = olast_q;
    odata_d = odata_q;
    okeep_d = okeep_q;
    ouser_d = ouser_q;
    if (load) begin
      ovld_d = 1'b1;
      {olast_d, ouser_d, okeep_d, odata_d} = head;
    end else if (ext_in_ready) begin
      ovld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= {axis_in_tlast, axis_in_tuser,
                                axis_in_tkeep, axis_in_tdata};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      avail_q    <= '0;
      cpl_q      <= '0;
      wr_cmt_q   <= 1'b0;
      last_cmt_q <= 1'b0;
      state_q    <= IDLE;
      cur_mode_q <= 1'b0;
      ovld_q     <= 1'b0;
      olast_q    <= 1'b0;
      odata_q    <= '0;
      okeep_q    <= '0;
      ouser_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      avail_q    <= avail_d;
      cpl_q      <= cpl_d;
      wr_cmt_q   <= wr_cmt_d;
      last_cmt_q <= last_cmt_d;
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      ovld_q     <= ovld_d;
      olast_q    <= olast_d;
      odata_q    <= odata_d;
      okeep_q    <= okeep_d;
      ouser_q    <= ouser_d;
    end
  end

`ifdef EGRESS_PORT_QUEUE_STATS_EN
  logic [CNT_W-1:0] rx_q, rx_d, tx_q, tx_d, byp_q, byp_d;

  always_comb begin
    rx_d  = rx_q;
    tx_d  = tx_q;
    byp_d = byp_q;
    if (wr && axis_in_tlast && rx_q != '1) rx_d = rx_q + CNT_W'(1);
    if (ovld_q && ext_in_ready && olast_q && tx_q != '1)
      tx_d = tx_q + CNT_W'(1);
    if (bypass_hit && byp_q != '1) byp_d = byp_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q  <= '0;
      tx_q  <= '0;
      byp_q <= '0;
    end else begin
      rx_q  <= rx_d;
      tx_q  <= tx_d;
      byp_q <= byp_d;
    end
  end

  assign pkt_rx_count     = rx_q;
  assign pkt_tx_count     = tx_q;
  assign saf_bypass_count = byp_q;
`else
  logic unused_bypass;
  assign unused_bypass    = bypass_hit;
  assign pkt_rx_count     = '0;
  assign pkt_tx_count     = '0;
  assign saf_bypass_count = '0;
`endif

  assign axis_in_tready = !full;
  assign ext_out_valid  = ovld_q;
  assign ext_out_data   = odata_q;
  assign ext_out_keep   = okeep_q;
  assign ext_out_user   = ouser_q;
  assign ext_out_last   = olast_q;
  assign fifo_level     = level_q;
  assign port_id        = 8'(PORT_ID);
endmodule

// File: tb/tb_egress_port_queue.sv
// Directed self-checking bench for egress_port_queue.
// Expected counters follow EGRESS_PORT_QUEUE_STATS_EN.
module tb_egress_port_queue;
  localparam int DW = 64, UW = 64, DEPTH = 16, CW = 32;
`ifdef EGRESS_PORT_QUEUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, saf_mode = 1'b0;
  logic axis_in_tvalid = 1'b0, axis_in_tlast = 1'b0, axis_in_tready;
  logic [DW-1:0] axis_in_tdata = '0;
  logic [DW/8-1:0] axis_in_tkeep = '1;
  logic [UW-1:0] axis_in_tuser = '0;
  logic ext_out_valid, ext_out_last, ext_in_ready = 1'b1;
  logic [DW-1:0] ext_out_data;
  logic [DW/8-1:0] ext_out_keep;
  logic [UW-1:0] ext_out_user;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [7:0] port_id;
  logic [CW-1:0] pkt_rx_count, pkt_tx_count, saf_bypass_count;

  egress_port_queue #(.PORT_ID(3), .DATA_W(DW), .USER_W(UW),
    .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .saf_mode(saf_mode),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tdata(axis_in_tdata),
    .axis_in_tkeep(axis_in_tkeep), .axis_in_tuser(axis_in_tuser),
    .axis_in_tlast(axis_in_tlast), .axis_in_tready(axis_in_tready),
    .ext_out_valid(ext_out_valid), .ext_out_data(ext_out_data),
    .ext_out_keep(ext_out_keep), .ext_out_user(ext_out_user),
    .ext_out_last(ext_out_last), .ext_in_ready(ext_in_ready),
    .fifo_level(fifo_level), .port_id(port_id),
    .pkt_rx_count(pkt_rx_count), .pkt_tx_count(pkt_tx_count),
    .saf_bypass_count(saf_bypass_count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0, nerr = 0;
  int first_vld = -1, hs_cyc = 0;
  int exp_rx = 0, exp_tx = 0, exp_byp = 0;
  logic [63:0] gotd[$], gotu[$], expd[$];
  bit gotl[$], expl[$];
  int gotc[$];

  always @(negedge clk) begin
    if (rst_n && ext_out_valid && first_vld < 0) first_vld = cyc;
    if (rst_n && ext_out_valid && ext_in_ready) begin
      gotd.push_back(ext_out_data);
      gotu.push_back(ext_out_user);
      gotl.push_back(ext_out_last);
      gotc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input bit l);
    bit ok = 1'b0;
    int n = 0;
    axis_in_tvalid = 1'b1;
    axis_in_tdata  = d;
    axis_in_tuser  = ~d;
    axis_in_tlast  = l;
    do begin
      @(negedge clk) ok = axis_in_tready;
      @(posedge clk) #1;
      n++;
    end while (!ok && n < 500);
    check("push_ok", 64'(ok), 64'd1);
    hs_cyc = cyc;
    expd.push_back(d);
    expl.push_back(l);
    axis_in_tvalid = 1'b0;
    axis_in_tlast  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (gotd.size() < expd.size() && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_n"}, 64'(gotd.size()), 64'(expd.size()));
    for (int i = 0; i < expd.size() && i < gotd.size(); i++) begin
      check({tag, "_d"}, gotd[i], expd[i]);
      check({tag, "_u"}, gotu[i], ~expd[i]);
      check({tag, "_l"}, 64'(gotl[i]), 64'(expl[i]));
    end
  endtask

  task automatic clr();
    gotd.delete(); gotu.delete(); gotl.delete(); gotc.delete();
    expd.delete(); expl.delete();
  endtask

  task automatic chk_cnt(input string tag);
    check({tag, "_rx"}, 64'(pkt_rx_count), STATS ? 64'(exp_rx) : 64'd0);
    check({tag, "_tx"}, 64'(pkt_tx_count), STATS ? 64'(exp_tx) : 64'd0);
    check({tag, "_byp"}, 64'(saf_bypass_count),
          STATS ? 64'(exp_byp) : 64'd0);
  endtask

  initial begin
    int h0, k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vld", 64'(ext_out_valid), 64'd0);
    check("rst_lvl", 64'(fifo_level), 64'd0);
    check("rst_data", ext_out_data, 64'd0);
    check("rst_last", 64'(ext_out_last), 64'd0);
    chk_cnt("rst");
    check("port_id", 64'(port_id), 64'd3);
    @(posedge clk) #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", 64'(axis_in_tready), 64'd1);

    // cut-through 3-beat packet
    @(posedge clk) #1;
    first_vld = -1;
    push(64'h11, 1'b0); h0 = hs_cyc;
    push(64'h22, 1'b0);
    push(64'h33, 1'b1);
    drain("ct");
    check("ct_lat", 64'(first_vld - h0), 64'd2);
    exp_rx++; exp_tx++;
    chk_cnt("ct");
    clr();

    // store-and-forward 4-beat packet
    saf_mode = 1'b1;
    first_vld = -1;
    for (int i = 0; i < 4; i++) push(64'hA0 + 64'(i), i == 3);
    drain("saf");
    check("saf_lat", 64'(first_vld - hs_cyc), 64'd2);
    if (gotc.size() == 4) check("saf_b2b", 64'(gotc[3] - gotc[0]), 64'd3);
    else check("saf_cnt", 64'(gotc.size()), 64'd4);
    exp_rx++; exp_tx++;
    chk_cnt("saf");
    clr();

    // backpressure fill
    saf_mode = 1'b0;
    ext_in_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 25; i++) begin
      axis_in_tvalid = 1'b1;
      axis_in_tdata  = 64'h100 + 64'(k);
      axis_in_tuser  = ~axis_in_tdata;
      axis_in_tlast  = (k == 16);
      @(negedge clk);
      if (axis_in_tready) begin
        expd.push_back(axis_in_tdata);
        expl.push_back(axis_in_tlast);
        k++;
      end
      @(posedge clk) #1;
    end
    axis_in_tvalid = 1'b0;
    axis_in_tlast  = 1'b0;
    @(negedge clk);
    check("bp_acc", 64'(k), 64'd17);
    check("bp_lvl", 64'(fifo_level), 64'd16);
    check("bp_rdy", 64'(axis_in_tready), 64'd0);
    check("bp_vld", 64'(ext_out_valid), 64'd1);
    check("bp_hold", ext_out_data, 64'h100);
    @(posedge clk) #1 ext_in_ready = 1'b1;
    drain("bp");
    check("bp_lvl0", 64'(fifo_level), 64'd0);
    exp_rx++; exp_tx++;
    chk_cnt("bp");
    clr();

    // SAF overflow into bypass
    saf_mode = 1'b1;
    for (int i = 0; i < 24; i++) push(64'h200 + 64'(i), i == 23);
    drain("ovf");
    exp_rx++; exp_tx++; exp_byp++;
    chk_cnt("ovf");
    clr();
    first_vld = -1;
    push(64'h250, 1'b0);
    push(64'h251, 1'b1);
    drain("ovf2");
    check("ovf2_lat", 64'(first_vld - hs_cyc), 64'd2);
    exp_rx++; exp_tx++;
    chk_cnt("ovf2");
    clr();

    // mode toggled mid-packet
    saf_mode = 1'b0;
    first_vld = -1;
    push(64'h300, 1'b0); h0 = hs_cyc;
    push(64'h301, 1'b0);
    push(64'h302, 1'b0);
    saf_mode = 1'b1;
    push(64'h303, 1'b1);
    drain("tgA");
    check("tgA_lat", 64'(first_vld - h0), 64'd2);
    clr();
    first_vld = -1;
    push(64'h310, 1'b0);
    push(64'h311, 1'b0);
    push(64'h312, 1'b1);
    drain("tgB");
    check("tgB_lat", 64'(first_vld - hs_cyc), 64'd2);
    exp_rx += 2; exp_tx += 2;
    chk_cnt("tg");
    clr();

    // reset with beats buffered
    saf_mode = 1'b0;
    ext_in_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(64'h400 + 64'(i), 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mr_lvl", 64'(fifo_level), 64'd4);
    check("mr_vld", 64'(ext_out_valid), 64'd1);
    @(posedge clk) #1 rst_n = 1'b0;
    @(posedge clk) #1 rst_n = 1'b1;
    @(negedge clk);
    check("mr_vld0", 64'(ext_out_valid), 64'd0);
    check("mr_lvl0", 64'(fifo_level), 64'd0);
    check("mr_rdy", 64'(axis_in_tready), 64'd1);
    check("mr_data", ext_out_data, 64'd0);
    exp_rx = 0; exp_tx = 0; exp_byp = 0;
    chk_cnt("mr");
    clr();
    @(posedge clk) #1 ext_in_ready = 1'b1;
    push(64'h500, 1'b0);
    push(64'h501, 1'b1);
    drain("post");
    exp_rx++; exp_tx++;
    chk_cnt("post");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
